// File: rtl/alu_requester.sv
// alu_requester: queues ALU commands in a FIFO, drives a registered ALU,
// waits SETTLE cycles, then returns the captured result with a 4-bit tag.
//
// Parameters : DEPTH  - command FIFO entries (power of two, 2..16)
//              SETTLE - cycles from ALU drive to result capture (1..15)
// Ports      : clk, rst_n (synchronous, active-low)
//              cmd_valid/cmd_ready, cmd_a, cmd_b, cmd_opcode - command in
//              alu_a, alu_b, alu_opcode                       - ALU drive
//              alu_out, alu_negative, alu_overflow, alu_zero  - ALU result
//              rsp_valid/rsp_ready, rsp_out, rsp_flags,
//              rsp_tag, rsp_err                               - response out
//              busy - engine active or commands pending
// Option     : define ALU_REQ_FLAG_CHECK_EN to flag results whose zero or
//              negative flag disagrees with the captured value (rsp_err).

package alu_pkg;
    typedef logic [7:0] data_t;
    typedef logic [2:0] opcode_t;

    localparam opcode_t OP_ADD = 3'd0;
    localparam opcode_t OP_SUB = 3'd1;
    localparam opcode_t OP_AND = 3'd2;
    localparam opcode_t OP_OR  = 3'd3;
    localparam opcode_t OP_XOR = 3'd4;
endpackage

module alu_requester
    import alu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1,
    localparam int DW    = $bits(data_t),
    localparam int OW    = $bits(opcode_t)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [DW-1:0] cmd_a,
    input  logic [DW-1:0] cmd_b,
    input  logic [OW-1:0] cmd_opcode,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [OW-1:0] alu_opcode,
    input  logic [DW-1:0] alu_out,
    input  logic          alu_negative,
    input  logic          alu_overflow,
    input  logic          alu_zero,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_out,
    output logic [2:0]    rsp_flags,
    output logic [3:0]    rsp_tag,
    output logic          rsp_err,
    output logic          busy
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [DW-1:0] r_mem_a  [DEPTH];
    logic [DW-1:0] r_mem_b  [DEPTH];
    logic [OW-1:0] r_mem_op [DEPTH];

    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [3:0]    r_cnt;
    logic [3:0]    r_tag;
    logic [3:0]    r_rsp_tag;
    logic [DW-1:0] r_alu_a;
    logic [DW-1:0] r_alu_b;
    logic [OW-1:0] r_alu_op;
    logic [DW-1:0] r_rsp_out;
    logic [2:0]    r_rsp_flags;
    logic          r_rsp_valid;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_capture;
    logic w_accept;

    // Extra MSB on the pointers tells a full ring from an empty one.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // Held low while reset is asserted so nothing is offered into a
    // FIFO that is being cleared.
    assign cmd_ready = rst_n && !w_full;
    assign w_push    = cmd_valid && cmd_ready;

    always_comb begin
        w_next    = r_state;
        w_pop     = 1'b0;
        w_capture = 1'b0;
        w_accept  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop  = 1'b1;
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                // Capture on the edge that takes the counter to zero.
                if (r_cnt <= 4'd1) begin
                    w_capture = 1'b1;
                    w_next    = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_accept = 1'b1;
                    w_next   = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr[AW-1:0]]  <= cmd_a;
            r_mem_b[r_wr_ptr[AW-1:0]]  <= cmd_b;
            r_mem_op[r_wr_ptr[AW-1:0]] <= cmd_opcode;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_alu_op <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_pop) begin
                r_alu_a  <= r_mem_a[r_rd_ptr[AW-1:0]];
                r_alu_b  <= r_mem_b[r_rd_ptr[AW-1:0]];
                r_alu_op <= r_mem_op[r_rd_ptr[AW-1:0]];
                r_cnt    <= 4'(SETTLE);
            end else if (w_capture) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_out   <= '0;
            r_rsp_flags <= '0;
            r_rsp_tag   <= '0;
            r_tag       <= '0;
        end else begin
            if (w_capture) begin
                r_rsp_valid <= 1'b1;
                r_rsp_out   <= alu_out;
                r_rsp_flags <= {alu_negative, alu_overflow, alu_zero};
                r_rsp_tag   <= r_tag;
            end else if (w_accept) begin
                r_rsp_valid <= 1'b0;
                r_tag       <= r_tag + 4'd1;
            end
        end
    end

`ifdef ALU_REQ_FLAG_CHECK_EN
    logic r_err;
    logic w_err;

    assign w_err = (alu_zero != (alu_out == '0)) ||
                   (alu_negative != alu_out[DW-1]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_capture) begin
            r_err <= w_err;
        end else if (w_accept) begin
            r_err <= 1'b0;
        end
    end

    assign rsp_err = r_err;
`else
    assign rsp_err = 1'b0;
`endif

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_opcode = r_alu_op;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_out    = r_rsp_out;
    assign rsp_flags  = r_rsp_flags;
    assign rsp_tag    = r_rsp_tag;
    assign busy       = (r_state != S_IDLE) || !w_empty;

endmodule

// File: doc/alu_requester.md
ALU_REQUESTER -- requirements
Module: alu_requester

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO depth in entries; power of two, 2..16.
REQ-002 Parameter SETTLE, default 1, cycles between driving ALU inputs and sampling ALU outputs; 1..15.
REQ-003 Widths: DW = width of alu_pkg::data_t; OW = width of alu_pkg::opcode_t.
REQ-004 Clocking, fixed: one clock; reset is synchronous and active-low.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 cmd_valid  input  1  command offered.
REQ-008 cmd_ready  output  1  command FIFO can accept.
REQ-009 cmd_a, cmd_b  input  DW each  operands.
REQ-010 cmd_opcode  input  OW  operation.
REQ-011 alu_a, alu_b  output  DW each  registered drive to ALU a/b.
REQ-012 alu_opcode  output  OW  registered drive to ALU opcode.
REQ-013 alu_out  input  DW  ALU result.
REQ-014 alu_negative, alu_overflow, alu_zero  input  1 each  ALU flags.
REQ-015 rsp_valid  output  1  response held.
REQ-016 rsp_ready  input  1  consumer accepts response.
REQ-017 rsp_out  output  DW  captured result.
REQ-018 rsp_flags  output  3  captured {negative, overflow, zero}.
REQ-019 rsp_tag  output  4  sequence number of the command, mod 16.
REQ-020 rsp_err  output  1  flag-consistency error (see Configuration).
REQ-021 busy  output  1  high when FSM not IDLE or FIFO not empty.

Function
REQ-022 Command handshake: entry written when cmd_valid && cmd_ready at a rising edge; cmd_ready = !full, independent of cmd_valid and of a same-cycle pop.
REQ-023 FIFO: circular, pointers wrap DEPTH-1 -> 0; full/empty via an extra pointer bit; order preserved.
REQ-024 FSM states: IDLE, WAIT, RESP.
REQ-025 IDLE && !empty: pop head, load alu_a/alu_b/alu_opcode from it, load settle counter with SETTLE, go to WAIT.
REQ-026 IDLE && empty: alu_* hold their last values.
REQ-027 WAIT: counter decrements each cycle; on the edge where it reaches 0, capture alu_out and flags into rsp_out/rsp_flags, assert rsp_valid, go to RESP.
REQ-028 RESP: rsp_* stable while rsp_valid && !rsp_ready; on rsp_valid && rsp_ready, deassert rsp_valid, increment tag counter (wraps 15 -> 0), go to IDLE.
REQ-029 Latency, empty FIFO and IDLE: handshake at edge t; alu_* updated at t+1; rsp_valid high from t+1+SETTLE.
REQ-030 Throughput: one command per SETTLE+2 cycles with rsp_ready held high; pop in IDLE may coincide with a push.
REQ-031 rsp_tag = tag counter value when the response was captured; first response after reset carries tag 0.

Reset
REQ-032 rst_n low at an edge: FIFO emptied, FSM to IDLE, settle counter 0, tag counter 0; any in-flight command and held response discarded.
REQ-033 Output values while reset is applied and on the first cycle after release: cmd_ready 0 during reset and 1 after release; alu_a, alu_b, alu_opcode 0; rsp_valid 0; rsp_out 0; rsp_flags 0; rsp_tag 0; rsp_err 0; busy 0.

Configuration
REQ-034 Macro ALU_REQ_FLAG_CHECK_EN defined: at capture, rsp_err = (alu_zero != (alu_out == 0)) || (alu_negative != alu_out[DW-1]); rsp_err is held with the response and cleared with rsp_valid.
REQ-035 ALU_REQ_FLAG_CHECK_EN undefined: rsp_err tied to 0 and no check logic is instantiated.

Verification (DW=8, DEPTH=4, SETTLE=1, behavioural ALU model on alu_*)
REQ-036 Reset, then one command a=8'h05, b=8'h03 with an add opcode at edge t -> alu_a=05 at t+1; rsp_valid at t+2; rsp_out=8'h08, flags=3'b000, tag 0.
REQ-037 rsp_ready held low, 6 commands offered back to back -> exactly 4 accepted after the first pops (cmd_ready low when full); responses return in order with tags 0,1,2,... and no loss.
REQ-038 Subtract opcode, a=8'h03, b=8'h03 -> rsp_out=8'h00, rsp_flags=3'b001; then a=8'h00, b=8'h01 -> rsp_out=8'hFF, negative=1.
REQ-039 17 commands with rsp_ready=1 -> 17th response has tag 0 (wrap); rsp_valid never high for more than one cycle.
REQ-040 rst_n low for 1 cycle while in WAIT with 2 entries queued -> next cycle rsp_valid=0, busy=0, cmd_ready=1; next response has tag 0.
REQ-041 ALU_REQ_FLAG_CHECK_EN defined, model forces alu_zero=1 with alu_out=8'h01 -> rsp_err=1; macro undefined -> rsp_err=0.
